// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared state encoding and bus constants for the I2C target responder
package iic_pkg;

   typedef enum logic [9:0] {
      ST_IDLE   = 10'b00_0000_0001,
      ST_ADDR   = 10'b00_0000_0010,
      ST_IGNORE = 10'b00_0000_0100,
      ST_A_ACK  = 10'b00_0000_1000,
      ST_PTR    = 10'b00_0001_0000,
      ST_P_ACK  = 10'b00_0010_0000,
      ST_WDATA  = 10'b00_0100_0000,
      ST_D_ACK  = 10'b00_1000_0000,
      ST_RDATA  = 10'b01_0000_0000,
      ST_M_ACK  = 10'b10_0000_0000
   } state_t;

   localparam logic       ACK          = 1'b0;
   localparam logic       NACK         = 1'b1;
   localparam logic       RW_WRITE     = 1'b0;
   localparam logic       RW_READ      = 1'b1;
   localparam logic [6:0] GENERAL_CALL = 7'h00;

   // Slots in which the target itself pulls SDA low to acknowledge.
   function automatic logic is_ack_slot(state_t s);
      return (s == ST_A_ACK) || (s == ST_P_ACK) || (s == ST_D_ACK);
   endfunction

   function automatic logic is_data_state(state_t s);
      return (s == ST_ADDR) || (s == ST_PTR) || (s == ST_WDATA) || (s == ST_RDATA);
   endfunction

endpackage

// File: rtl/iic_line_filter.sv
// rtl/iic_line_filter.sv - two-flop synchroniser, run-length glitch filter and edge detect for one I2C line
module iic_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic filt,
   output logic rise,
   output logic fall
);

   logic [1:0] sync;
   logic [3:0] run_cnt;

   // A new level is accepted only after FILT_LEN consecutive synced samples disagree with the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= 2'b11;
         run_cnt <= '0;
         filt    <= 1'b1;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] == filt) begin
            run_cnt <= '0;
         end else if (run_cnt == 4'(FILT_LEN - 1)) begin
            run_cnt <= '0;
            filt    <= sync[1];
            rise    <= sync[1];
            fall    <= ~sync[1];
         end else begin
            run_cnt <= run_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/iic_slave_responder.sv
// rtl/iic_slave_responder.sv - I2C target: address match, register pointer, auto-incrementing register read/write
module iic_slave_responder
   import iic_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h3C,
   parameter int         FILT_LEN   = 3,
   parameter int         HOLD_CLKS  = 4
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       IICSCL,
   inout  wire        IICSDA,
   output logic [7:0] reg_addr,
   output logic       reg_wr_en,
   output logic [7:0] reg_wr_data,
   output logic       reg_rd_en,
   input  logic [7:0] reg_rd_data,
   output logic       busy,
   output logic       addr_nack
);

   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;

   iic_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
      .clk(sys_clk), .rst_n(rst_n), .din(IICSCL),
      .filt(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   iic_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
      .clk(sys_clk), .rst_n(rst_n), .din(IICSDA),
      .filt(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;

   state_t     state, state_next;
   logic [3:0] bit_cnt;
   logic [7:0] shift, ptr, hold_cnt;
   logic       rw, sda_oe, rd_load;
   logic [7:0] byte_in;
   logic       wr_pulse, rd_pulse, ptr_load, ptr_inc, nack_pulse, match, drive_want;

   assign byte_in  = {shift[6:0], sda_f};
   assign reg_addr = ptr;
   assign IICSDA   = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Byte slots end on the scl_fall after the 8th rise, so each ACK state spans exactly its ninth clock.
   always_comb begin
      state_next = state;
      wr_pulse   = 1'b0;
      rd_pulse   = 1'b0;
      ptr_load   = 1'b0;
      ptr_inc    = 1'b0;
      nack_pulse = 1'b0;
      match      = 1'b0;
      case (state)
         ST_ADDR: begin
            if (scl_rise && bit_cnt == 4'd7) begin
               if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != GENERAL_CALL) begin
                  match = 1'b1;
               end else begin
                  nack_pulse = 1'b1;
                  state_next = ST_IGNORE;
               end
            end
            if (scl_fall && bit_cnt == 4'd8) state_next = ST_A_ACK;
         end
         ST_A_ACK: begin
            if (scl_rise && rw == RW_READ) rd_pulse = 1'b1;
            if (scl_fall) state_next = (rw == RW_READ) ? ST_RDATA : ST_PTR;
         end
         ST_PTR: begin
            if (scl_rise && bit_cnt == 4'd7) ptr_load = 1'b1;
            if (scl_fall && bit_cnt == 4'd8) state_next = ST_P_ACK;
         end
         ST_P_ACK: begin
            if (scl_fall) state_next = ST_WDATA;
         end
         ST_WDATA: begin
            if (scl_rise && bit_cnt == 4'd7) wr_pulse = 1'b1;
            if (scl_fall && bit_cnt == 4'd8) state_next = ST_D_ACK;
         end
         ST_D_ACK: begin
            if (scl_fall) begin
               ptr_inc    = 1'b1;
               state_next = ST_WDATA;
            end
         end
         ST_RDATA: begin
            if (scl_fall && bit_cnt == 4'd8) state_next = ST_M_ACK;
         end
         ST_M_ACK: begin
            // The pointer moves past every byte handed out, whether the master ACKs it or not.
            if (scl_rise) begin
               ptr_inc = 1'b1;
               if (sda_f == ACK) rd_pulse = 1'b1;
               else              state_next = ST_IGNORE;
            end
            if (scl_fall) state_next = ST_RDATA;
         end
         default: ;
      endcase
      if (start_det || stop_det) begin
         state_next = start_det ? ST_ADDR : ST_IDLE;
         wr_pulse   = 1'b0;
         rd_pulse   = 1'b0;
         ptr_load   = 1'b0;
         ptr_inc    = 1'b0;
         nack_pulse = 1'b0;
         match      = 1'b0;
      end
   end

   always_comb begin
      drive_want = 1'b0;
      if (is_ack_slot(state))    drive_want = 1'b1;
      else if (state == ST_RDATA) drive_want = ~shift[7];
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= '0;
         shift       <= '0;
         ptr         <= '0;
         rw          <= RW_WRITE;
         busy        <= 1'b0;
         addr_nack   <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_data <= '0;
         reg_rd_en   <= 1'b0;
         rd_load     <= 1'b0;
         sda_oe      <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         reg_wr_en <= wr_pulse;
         reg_rd_en <= rd_pulse;
         addr_nack <= nack_pulse;
         rd_load   <= reg_rd_en;
         if (wr_pulse) reg_wr_data <= byte_in;
         if (match)    rw <= byte_in[0];

         if (start_det || stop_det) busy <= 1'b0;
         else if (match)            busy <= 1'b1;

         if (start_det || stop_det)                   bit_cnt <= '0;
         else if (scl_rise && is_data_state(state))   bit_cnt <= bit_cnt + 4'd1;
         else if (scl_fall && bit_cnt == 4'd8)        bit_cnt <= '0;

         if (rd_load)
            shift <= reg_rd_data;
         else if (scl_rise && is_data_state(state))
            shift <= (state == ST_RDATA) ? {shift[6:0], 1'b1} : byte_in;

         if (ptr_load)     ptr <= byte_in;
         else if (ptr_inc) ptr <= ptr + 8'd1;

         // Release at every SCL fall, then apply the slot's drive level after the data hold time.
         if (start_det || stop_det) begin
            sda_oe   <= 1'b0;
            hold_cnt <= '0;
         end else if (scl_fall) begin
            sda_oe   <= 1'b0;
            hold_cnt <= 8'(HOLD_CLKS);
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_cnt == 8'd1) sda_oe <= drive_want;
         end
      end
   end

endmodule
